// File: rtl/wb_queue.sv
// wb_queue: in-order write-back queue merging ALU and LSU results into one
// regfile write port. It retires one entry per cycle. The LSU takes priority
// when only one slot is free. Destinations of x0 are accepted and dropped.
// Optional bypass snoop of pending entries: define WB_QUEUE_BYPASS_EN.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        wen,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic        byp_hit1,
    output logic        byp_hit2,
    output logic [31:0] byp_data1,
    output logic [31:0] byp_data2,
    output logic [3:0]  count,
    output logic        full,
    output logic        empty
);
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] head, tail, alu_idx;
    logic [4:0]    ent_rd   [DEPTH];
    logic [31:0]   ent_data [DEPTH];
    logic [4:0]    slots;
    logic          lsu_push, alu_push, pop;
    logic [1:0]    npush;

    // Free slots this cycle; the head pop frees one more whenever non-empty.
    assign slots     = 5'(DEPTH) - {1'b0, count} + {4'b0, (count != 4'd0)};
    assign lsu_ready = !rst && (slots >= 5'd1);
    assign alu_ready = !rst && ((slots >= 5'd2) || ((slots >= 5'd1) && !lsu_valid));

    // x0 handshakes complete but never occupy a slot.
    assign lsu_push = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
    assign alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
    assign npush    = {1'b0, lsu_push} + {1'b0, alu_push};
    assign alu_idx  = tail + PW'(lsu_push);

    assign empty = (count == 4'd0);
    assign full  = (count == 4'(DEPTH));
    assign pop   = !empty;
    assign wen   = !empty;
    assign waddr = empty ? 5'd0  : ent_rd[head];
    assign wdata = empty ? 32'd0 : ent_data[head];

    // Queue state: pop at head, LSU then ALU appended at tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd[i]   <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            if (lsu_push) begin
                ent_rd[tail]   <= lsu_rd;
                ent_data[tail] <= lsu_data;
            end
            if (alu_push) begin
                ent_rd[alu_idx]   <= alu_rd;
                ent_data[alu_idx] <= alu_data;
            end
            head  <= head + PW'(pop);
            tail  <= tail + PW'(npush);
            count <= count + 4'(npush) - 4'(pop);
        end
    end

`ifdef WB_QUEUE_BYPASS_EN
    // Age-ordered search from head; later (younger) matches overwrite earlier ones.
    always_comb begin
        logic [PW-1:0] bi;
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            bi = head + PW'(k);
            if ((4'(k) < count) && (raddr1 != 5'd0) && (ent_rd[bi] == raddr1)) begin
                byp_hit1  = 1'b1;
                byp_data1 = ent_data[bi];
            end
            if ((4'(k) < count) && (raddr2 != 5'd0) && (ent_rd[bi] == raddr2)) begin
                byp_hit2  = 1'b1;
                byp_data2 = ent_data[bi];
            end
        end
    end
`else
    logic unused_raddr;
    assign unused_raddr = ^{raddr1, raddr2};
    assign byp_hit1  = 1'b0;
    assign byp_hit2  = 1'b0;
    assign byp_data1 = '0;
    assign byp_data2 = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed and randomized checks of wb_queue against a
// queue-based reference model of the write-back ordering rules.
module tb_wb_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid;
    logic        alu_ready, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd, raddr1, raddr2, waddr;
    logic [31:0] alu_data, lsu_data, wdata, byp_data1, byp_data2;
    logic        wen, byp_hit1, byp_hit2, full, empty;
    logic [3:0]  count;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Free space seen by producers: the retiring head frees its slot this cycle.
    function automatic int mfree();
        return DEPTH - q.size() + ((q.size() > 0) ? 1 : 0);
    endfunction

    // Youngest pending entry with matching destination; x0 never matches.
    function automatic void mbyp(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
`ifdef WB_QUEUE_BYPASS_EN
        if (a != 5'd0)
            for (int i = 0; i < q.size(); i++)
                if (q[i].rd == a) begin
                    h = 1'b1;
                    d = q[i].data;
                end
`endif
    endfunction

    // Apply one rising edge to the model using the inputs currently driven.
    task automatic model_edge();
        bit lr, ar;
        lr = mfree() >= 1;
        ar = (mfree() >= 2) || ((mfree() >= 1) && !lsu_valid);
        if (q.size() > 0) void'(q.pop_front());
        if (lsu_valid && lr && lsu_rd != 5'd0) q.push_back('{lsu_rd, lsu_data});
        if (alu_valid && ar && alu_rd != 5'd0) q.push_back('{alu_rd, alu_data});
    endtask

    task automatic idle();
        alu_valid = 0; lsu_valid = 0;
        alu_rd = 0; lsu_rd = 0; alu_data = 0; lsu_data = 0;
        raddr1 = 0; raddr2 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < DEPTH + 1; i++) tick();
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        #1;
        nvec++;
        if ({wen, waddr, wdata, count, empty, full, alu_ready, lsu_ready} !==
            {1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            nerr++;
            $display("FAIL reset_outputs got wen=%b waddr=%0d wdata=%h count=%0d empty=%b full=%b rdy=%b%b exp 0/0/0/0/1/0/00",
                     wen, waddr, wdata, count, empty, full, alu_ready, lsu_ready);
        end
        nvec++;
        if ({byp_hit1, byp_hit2, byp_data1, byp_data2} !== 66'd0) begin
            nerr++;
            $display("FAIL reset_bypass got hit=%b%b d1=%h d2=%h exp zeros", byp_hit1, byp_hit2, byp_data1, byp_data2);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        q.delete();
        #1;
        nvec++;
        if ({lsu_ready, alu_ready} !== 2'b11) begin
            nerr++;
            $display("FAIL post_reset_ready got %b%b exp 11", lsu_ready, alu_ready);
        end
    endtask

    task automatic test_single_write();
        idle();
        lsu_valid = 1; lsu_rd = 5'd1; lsu_data = 32'hdeadbeef;
        tick();
        idle();
        #1;
        nvec++;
        if ({wen, waddr, wdata, count} !== {1'b1, 5'd1, 32'hdeadbeef, 4'd1}) begin
            nerr++;
            $display("FAIL single_write got wen=%b waddr=%0d wdata=%h count=%0d exp 1/1/deadbeef/1", wen, waddr, wdata, count);
        end
        tick();
        #1;
        nvec++;
        if ({empty, wen, waddr, wdata} !== {1'b1, 1'b0, 5'd0, 32'd0}) begin
            nerr++;
            $display("FAIL single_empty got empty=%b wen=%b waddr=%0d wdata=%h exp 1/0/0/0", empty, wen, waddr, wdata);
        end
    endtask

    task automatic test_dual_accept();
        idle();
        alu_valid = 1; alu_rd = 5'd2; alu_data = 32'hbaadcafe;
        lsu_valid = 1; lsu_rd = 5'd3; lsu_data = 32'hcafed00d;
        #1;
        nvec++;
        if ({lsu_ready, alu_ready} !== 2'b11) begin
            nerr++;
            $display("FAIL dual_ready got %b%b exp 11", lsu_ready, alu_ready);
        end
        tick();
        idle();
        #1;
        nvec++;
        if ({wen, waddr, wdata, count} !== {1'b1, 5'd3, 32'hcafed00d, 4'd2}) begin
            nerr++;
            $display("FAIL dual_first got wen=%b waddr=%0d wdata=%h count=%0d exp 1/3/cafed00d/2", wen, waddr, wdata, count);
        end
        tick();
        #1;
        nvec++;
        if ({wen, waddr, wdata} !== {1'b1, 5'd2, 32'hbaadcafe}) begin
            nerr++;
            $display("FAIL dual_second got wen=%b waddr=%0d wdata=%h exp 1/2/baadcafe", wen, waddr, wdata);
        end
        tick();
    endtask

    task automatic test_full();
        idle();
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_rd = 5'(10 + 2 * i); alu_data = 32'(100 + i);
            lsu_valid = 1; lsu_rd = 5'(11 + 2 * i); lsu_data = 32'(200 + i);
            tick();
        end
        #1;
        nvec++;
        if ({count, full} !== {4'd4, 1'b1}) begin
            nerr++;
            $display("FAIL full_fill got count=%0d full=%b exp 4/1", count, full);
        end
        alu_rd = 5'd20; alu_data = 32'h0a0a0a0a;
        lsu_rd = 5'd21; lsu_data = 32'h0b0b0b0b;
        #1;
        nvec++;
        if ({lsu_ready, alu_ready} !== 2'b10) begin
            nerr++;
            $display("FAIL full_ready got lsu=%b alu=%b exp 1/0", lsu_ready, alu_ready);
        end
        tick();
        idle();
        #1;
        nvec++;
        if ({count, full} !== {4'd4, 1'b1} || q[q.size()-1].rd != 5'd21) begin
            nerr++;
            $display("FAIL full_hold got count=%0d full=%b exp 4/1", count, full);
        end
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if ({wen, waddr, wdata} !== {1'b1, q[0].rd, q[0].data}) begin
                nerr++;
                $display("FAIL full_drain got waddr=%0d wdata=%h exp %0d/%h", waddr, wdata, q[0].rd, q[0].data);
            end
            tick();
            #1;
        end
        drain();
    endtask

    task automatic test_x0_drop();
        idle();
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hb105f00d;
        #1;
        nvec++;
        if (alu_ready !== 1'b1) begin
            nerr++;
            $display("FAIL x0_ready got %b exp 1", alu_ready);
        end
        tick();
        idle();
        #1;
        nvec++;
        if ({count, wen, waddr} !== {4'd0, 1'b0, 5'd0}) begin
            nerr++;
            $display("FAIL x0_drop got count=%0d wen=%b waddr=%0d exp 0/0/0", count, wen, waddr);
        end
    endtask

    task automatic test_bypass();
        logic        eh;
        logic [31:0] ed;
        idle();
        lsu_valid = 1; lsu_rd = 5'd1; lsu_data = 32'hdeadbeef;
        alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h8badf00d;
        raddr1 = 5'd1;
        #1;
        nvec++;
        if (byp_hit1 !== 1'b0) begin
            nerr++;
            $display("FAIL byp_same_cycle got %b exp 0", byp_hit1);
        end
        tick();
        alu_valid = 0; lsu_valid = 0;
        raddr1 = 5'd1; raddr2 = 5'd0;
        #1;
        mbyp(raddr1, eh, ed);
        nvec++;
        if ({byp_hit1, byp_data1} !== {eh, ed}) begin
            nerr++;
            $display("FAIL byp_youngest got hit=%b data=%h exp %b/%h", byp_hit1, byp_data1, eh, ed);
        end
        nvec++;
        if ({byp_hit2, byp_data2} !== 33'd0) begin
            nerr++;
            $display("FAIL byp_x0 got hit=%b data=%h exp 0/0", byp_hit2, byp_data2);
        end
        drain();
    endtask

    task automatic test_random();
        logic        eh1, eh2, ew;
        logic [31:0] ed1, ed2;
        for (int c = 0; c < 400; c++) begin
            alu_valid = ($urandom_range(0, 9) < 6);
            lsu_valid = ($urandom_range(0, 9) < 5);
            alu_rd    = 5'($urandom_range(0, 4));
            lsu_rd    = 5'($urandom_range(0, 4));
            alu_data  = $urandom;
            lsu_data  = $urandom;
            raddr1    = 5'($urandom_range(0, 4));
            raddr2    = 5'($urandom_range(0, 4));
            #1;
            ew = q.size() > 0;
            nvec++;
            if ({wen, waddr, wdata} !== {ew, ew ? q[0].rd : 5'd0, ew ? q[0].data : 32'd0}) begin
                nerr++;
                $display("FAIL rnd_write c=%0d got %b/%0d/%h exp %b/%0d/%h", c, wen, waddr, wdata,
                         ew, ew ? q[0].rd : 5'd0, ew ? q[0].data : 32'd0);
            end
            nvec++;
            if ({count, full, empty} !== {4'(q.size()), q.size() == DEPTH, q.size() == 0}) begin
                nerr++;
                $display("FAIL rnd_status c=%0d got count=%0d full=%b empty=%b exp count=%0d", c, count, full, empty, q.size());
            end
            nvec++;
            if ({lsu_ready, alu_ready} !== {mfree() >= 1, (mfree() >= 2) || (mfree() >= 1 && !lsu_valid)}) begin
                nerr++;
                $display("FAIL rnd_ready c=%0d got lsu=%b alu=%b free=%0d lsu_valid=%b", c, lsu_ready, alu_ready, mfree(), lsu_valid);
            end
            mbyp(raddr1, eh1, ed1);
            mbyp(raddr2, eh2, ed2);
            nvec++;
            if ({byp_hit1, byp_data1, byp_hit2, byp_data2} !== {eh1, ed1, eh2, ed2}) begin
                nerr++;
                $display("FAIL rnd_bypass c=%0d got %b/%h %b/%h exp %b/%h %b/%h", c,
                         byp_hit1, byp_data1, byp_hit2, byp_data2, eh1, ed1, eh2, ed2);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        idle();
        for (int i = 0; i < 2; i++) begin
            alu_valid = 1; alu_rd = 5'(5 + i); alu_data = 32'(i);
            lsu_valid = 1; lsu_rd = 5'(7 + i); lsu_data = 32'(i + 8);
            tick();
        end
        idle();
        #1;
        nvec++;
        if (count !== 4'd3) begin
            nerr++;
            $display("FAIL mid_prefill got count=%0d exp 3", count);
        end
        rst = 1;
        #1;
        nvec++;
        if ({wen, count, empty} !== {1'b0, 4'd0, 1'b1}) begin
            nerr++;
            $display("FAIL mid_reset got wen=%b count=%0d empty=%b exp 0/0/1", wen, count, empty);
        end
        q.delete();
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            nvec++;
            if ({wen, empty} !== 2'b01) begin
                nerr++;
                $display("FAIL mid_nowrite got wen=%b empty=%b exp 0/1", wen, empty);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_single_write();
        test_dual_accept();
        test_full();
        test_x0_drop();
        test_bypass();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout exp finish before 200000");
        $fatal(1);
    end
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, is the number of write-back queue entries; legal values are 2, 4 and 8.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 alu_valid  input  1  ALU result is offered.
REQ-005 alu_ready  output  1  queue accepts the ALU result this cycle.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  32  ALU result value.
REQ-008 lsu_valid  input  1  load result is offered.
REQ-009 lsu_ready  output  1  queue accepts the load result this cycle.
REQ-010 lsu_rd  input  5  load destination register.
REQ-011 lsu_data  input  32  load result value.
REQ-012 wen  output  1  regfile write enable.
REQ-013 waddr  output  5  regfile write address.
REQ-014 wdata  output  32  regfile write data.
REQ-015 raddr1, raddr2  input  5 each  regfile read addresses, snooped for bypass.
REQ-016 byp_hit1, byp_hit2  output  1 each  a pending queue entry matches raddr1 or raddr2.
REQ-017 byp_data1, byp_data2  output  32 each  data of the youngest matching entry.
REQ-018 count  output  4  number of occupied entries.
REQ-019 full, empty  output  1 each  count==DEPTH, count==0.

Function
REQ-020 The queue SHALL be an in-order circular FIFO with head and tail pointers that wrap modulo DEPTH.
REQ-021 A producer handshake SHALL complete on a rising edge when its valid and ready are both high.
REQ-022 slots SHALL equal DEPTH-count, plus 1 when count is nonzero, because a pop happens the same cycle.
REQ-023 lsu_ready SHALL equal (slots>=1).
REQ-024 alu_ready SHALL equal (slots>=2) OR (slots>=1 AND NOT lsu_valid), so the LSU has priority.
REQ-025 When both producers handshake in one cycle, the LSU entry SHALL be enqueued first, the ALU entry second, and the tail SHALL advance by 2.
REQ-026 A handshake with rd==0 SHALL be accepted and dropped; it is never enqueued.
REQ-027 wen SHALL equal NOT empty; waddr and wdata SHALL come from the head entry; the head SHALL pop on every edge where wen is high.
REQ-028 Latency: an entry enqueued at edge N into an empty queue SHALL drive wen in cycle N+1 and commit at edge N+1.
REQ-029 When wen is low, waddr and wdata SHALL be 0.
REQ-030 Bypass search SHALL cover all occupied entries; the youngest match SHALL win; an address of 0 SHALL never hit.
REQ-031 The bypass outputs SHALL be combinational from current queue state; entries arriving in the same cycle SHALL NOT be visible.
REQ-032 count, full and empty SHALL be registered-state derived; count SHALL never exceed DEPTH and never underflow.

Reset
REQ-033 rst high SHALL immediately clear the pointers, count, and all entry valid and data bits.
REQ-034 During reset: wen=0, waddr=0, wdata=0, count=0, empty=1, full=0, byp_hit*=0, byp_data*=0, alu_ready=0, lsu_ready=0.
REQ-035 Reset asserted mid-operation SHALL discard all pending writes, with no partial write issued.
REQ-036 On the first edge after reset deasserts, the ready outputs SHALL follow REQ-023 and REQ-024.

Configuration
REQ-037 Macro WB_QUEUE_BYPASS_EN SHALL control bypass.
REQ-038 With WB_QUEUE_BYPASS_EN defined, REQ-030 and REQ-031 apply.
REQ-039 Without WB_QUEUE_BYPASS_EN, byp_hit* and byp_data* SHALL be constant 0, no comparator logic SHALL exist, and the ports SHALL be retained.

Verification
REQ-040 Reset mid-stream: rst=1 with 3 entries queued -> wen=0, count=0 and empty=1 immediately; no further writes.
REQ-041 Single write: lsu rd=1, data=32'hdeadbeef at edge N -> wen=1, waddr=1, wdata=32'hdeadbeef in cycle N+1; empty at N+2.
REQ-042 Dual accept: alu rd=2, 32'hbaadcafe and lsu rd=3, 32'hcafed00d in the same cycle -> writes in order rd=3 then rd=2 on consecutive cycles.
REQ-043 Full with DEPTH=4, count=4 and both valid -> lsu_ready=1, alu_ready=0; only the LSU entry is enqueued; count stays 4; full holds.
REQ-044 x0 drop: alu rd=0, 32'hb105f00d handshakes -> count is unchanged; wen is never asserted with waddr=0.
REQ-045 Bypass (macro on): queue holds rd=1 with 32'hdeadbeef (older) and rd=1 with 32'h8badf00d (younger), raddr1=1 -> byp_hit1=1, byp_data1=32'h8badf00d; same stimulus with the macro off -> byp_hit1=0.
